// File: rtl/mux_n1_rr.sv
`default_nettype none
// ============================================================================
// Module      : mux_n1_rr
// Description : Parametrised N:1 valid multiplexer with registered output and
//               a downstream ready handshake. MODE 0 sweeps every channel in
//               turn; MODE 1 is a round-robin arbiter that skips idle channels.
// Revision    : 1.0  initial release
// ============================================================================
module mux_n1_rr #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 4,
    parameter int MODE     = 1,
    parameter int SEL_W    = ($clog2(CHANNELS) > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [CHANNELS-1:0]       valid_in,
    input  logic                      ready_out,
    output logic [CHANNELS-1:0]       grant,
    output logic [WIDTH-1:0]          data_out,
    output logic                      valid_out,
    output logic [SEL_W-1:0]          sel_out
);

    // Highest legal channel index; the pointer wraps on an explicit compare
    // so non-power-of-2 channel counts never visit an unused index.
    localparam logic [SEL_W-1:0] C_LAST_IDX = SEL_W'(CHANNELS - 1);

    logic [SEL_W-1:0] r_ptr;

    logic             w_load;
    logic             w_hi_found;
    logic             w_lo_found;
    logic [SEL_W-1:0] w_hi_pick;
    logic [SEL_W-1:0] w_lo_pick;
    logic             w_take;
    logic [SEL_W-1:0] w_cand;
    logic [SEL_W-1:0] w_cand_next;
    logic [WIDTH-1:0] w_cand_data;

    // The output register may accept a new word when empty or being drained.
    assign w_load = !valid_out || ready_out;

    // Round-robin search split in two halves: lowest valid channel at or
    // above the pointer, else lowest valid channel below it (the wrap).
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_pick  = '0;
        w_lo_pick  = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (valid_in[k]) begin
                if (SEL_W'(k) >= r_ptr) begin
                    w_hi_found = 1'b1;
                    w_hi_pick  = SEL_W'(k);
                end else begin
                    w_lo_found = 1'b1;
                    w_lo_pick  = SEL_W'(k);
                end
            end
        end
    end

    // Candidate channel and whether it carries a word, per selection mode.
    always_comb begin
        w_cand = r_ptr;
        w_take = 1'b0;
        if (MODE == 1) begin
            w_cand = w_hi_found ? w_hi_pick : w_lo_pick;
            w_take = w_hi_found || w_lo_found;
        end else begin
            w_cand = r_ptr;
            w_take = valid_in[r_ptr];
        end
    end

    // Index following the candidate, wrapping at the last channel.
    assign w_cand_next = (w_cand == C_LAST_IDX) ? '0 : w_cand + 1'b1;

    // Data path mux for the candidate channel; kept out of the grant logic.
    always_comb begin
        w_cand_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (SEL_W'(k) == w_cand) begin
                w_cand_data = data_in[k*WIDTH +: WIDTH];
            end
        end
    end

    // One-hot grant for the channel consumed at the coming edge.
    always_comb begin
        grant = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            grant[k] = !reset && w_load && w_take && (SEL_W'(k) == w_cand);
        end
    end

    // Output register and search pointer; everything holds during a stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            sel_out   <= '0;
            r_ptr     <= '0;
        end else if (w_load) begin
            valid_out <= w_take;
            if (w_take) begin
                data_out <= w_cand_data;
            end
            if (w_take || (MODE == 0)) begin
                sel_out <= w_cand;
                r_ptr   <= w_cand_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/mux_n1_rr.md
# mux_n1_rr

Parametrised N:1 data multiplexer with per-channel valid, registered output, and a downstream ready handshake. It generalises the 4:1 valid mux to any channel count and data width. A mode parameter selects between a strict rotating sweep, which visits every channel in turn, and a round-robin arbiter that skips idle channels. It sits between several producer lanes and a single consumer lane in the datapath.

## Interface
Parameters:
- CHANNELS, 4, number of input channels; legal range ≥ 2, need not be a power of 2.
- WIDTH, 4, data bits per channel.
- MODE, 1, selection mode:
  - 0 = strict sweep.
  - 1 = round-robin that skips channels with valid low.
- SEL_W, max(1, clog2(CHANNELS)), derived width of the channel index.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  CHANNELS*WIDTH  flattened inputs; channel k occupies bits [k*WIDTH +: WIDTH].
- valid_in  in  CHANNELS  per-channel valid.
- ready_out  in  1  downstream can accept the output word.
- grant  out  CHANNELS  combinational one-hot; bit k high means channel k is consumed at this edge.
- data_out  out  WIDTH  registered selected data.
- valid_out  out  1  registered; data_out holds a real word.
- sel_out  out  SEL_W  registered index of the channel that supplied data_out.

## Operation
- **Internal state:** pointer ptr (SEL_W bits), the start of the next search.
- **Load enable:** load = !valid_out || ready_out. When load = 0 (stall), data_out, valid_out, sel_out and ptr all hold, and grant = 0.
- **MODE 1 (round-robin), when load = 1:**
  - Search channels ptr, ptr+1, …, wrapping CHANNELS-1 → 0, for the first k with valid_in[k] = 1.
  - If found: grant[k] = 1; next edge sets data_out ← channel k, valid_out ← 1, sel_out ← k, ptr ← (k+1) mod CHANNELS.
  - If none found: grant = 0; valid_out ← 0; data_out and sel_out hold; ptr holds.
- **MODE 0 (sweep), when load = 1:**
  - Candidate is k = ptr.
  - grant[k] = valid_in[k].
  - valid_out ← valid_in[k]; sel_out ← k; data_out ← channel k if valid_in[k], else it holds.
  - ptr ← (ptr+1) mod CHANNELS on every load cycle, whether or not the candidate was valid.
- **Arithmetic:**
  - Pointer wrap is an explicit compare against CHANNELS-1, not natural overflow, so that non-power-of-2 counts work.
  - data is passed through unmodified, with no width change.
- **Simultaneous events:** a new valid arriving on a channel during a stall is not granted until load = 1. A producer must hold data and valid until it sees its grant bit.
- **Reset (async, any time, including mid-transfer):**
  - data_out = 0, valid_out = 0, sel_out = 0, ptr = 0, immediately.
  - grant = 0 while reset is high.
  - The first grant after release goes to the lowest valid channel at or after 0.

## Timing
- Latency is 1 cycle: a channel granted in cycle n appears on data_out/valid_out/sel_out after edge n.
- Throughput is one word per cycle while ready_out = 1.
- grant is purely combinational from valid_in, ptr, valid_out and ready_out. It has no path from data_in.
- ready_out → grant is a combinational path. Downstream logic must not make ready_out depend on grant.
- Output changes only at rising clk, or immediately on reset assertion.

## Test plan
All scenarios use the defaults CHANNELS=4, WIDTH=4 unless noted.
1. **Async reset:**
   - Stimulus: assert reset mid-stream between clock edges.
   - Response: valid_out, data_out and sel_out go to 0 without waiting for a clock edge, and grant = 0 while reset is high.
   - After release with valid_in = 4'b1111, sel_out sequence starts at 0.
2. **MODE 1, all channels valid:**
   - Stimulus: data = {F,5,A,0} (ch3..ch0), valid_in = 4'b1111, ready_out = 1.
   - Response: data_out = 0, A, 5, F, 0, …; sel_out = 0, 1, 2, 3, 0; valid_out high from the first cycle after the first edge.
3. **MODE 1, skip idle channels:**
   - Stimulus: valid_in = 4'b1010.
   - Response: sel_out = 1, 3, 1, 3; grant alternates 4'b0010 / 4'b1000.
   - With valid_in = 0: valid_out falls after 1 edge and ptr is unchanged.
4. **Backpressure:**
   - Stimulus: with valid_out = 1 and sel_out = 1, drop ready_out for 3 cycles.
   - Response: data_out and sel_out are held and grant = 0 throughout.
   - On ready_out = 1, the next sel_out = 2.
5. **MODE 0 sweep:**
   - Stimulus: valid_in = 4'b0101.
   - Response: sel_out = 0, 1, 2, 3; valid_out = 1, 0, 1, 0.
   - data_out holds the ch0 value through the ch1 slot.
6. **Non-power-of-2 wrap:**
   - Stimulus: CHANNELS = 3, MODE 1, all channels valid.
   - Response: sel_out = 0, 1, 2, 0, 1; sel_out never equals 3.
